// File: rtl/regfile_read_port.sv
// regfile_read_port
// Read side of the register file. It serves single registered reads with a
// one-cycle latency, and a scan mode that streams every register out, one
// per cycle, for debug and dump logic.
// Optional build macro: ZERO_REG_EN. When it is defined, index 0 always reads
// as zero, for both single reads and scans.
module regfile_read_port #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REGS    = 32,
    parameter int NBITS       = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REGS*WORD_LENGTH-1:0] Reg_Data,
    input  logic                            Read_Req,
    input  logic [NBITS-1:0]                Read_Addr,
    input  logic                            Scan_Start,
    output logic [WORD_LENGTH-1:0]          Read_Data,
    output logic [NBITS-1:0]                Read_Addr_Out,
    output logic                            Read_Valid,
    output logic                            Busy,
    output logic                            Scan_Done
);

    localparam int ADDR_SPACE = 1 << NBITS;
    localparam logic [NBITS-1:0] LAST_IDX = NBITS'(NUM_REGS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // FSM and output registers.
    state_t                 r_state;
    logic [NBITS-1:0]       r_cnt;
    logic [WORD_LENGTH-1:0] r_read_data;
    logic [NBITS-1:0]       r_read_addr_out;
    logic                   r_read_valid;
    logic                   r_busy;
    logic                   r_scan_done;

    // Next-state values from the combinational process.
    state_t                 w_state_next;
    logic [NBITS-1:0]       w_cnt_next;
    logic [WORD_LENGTH-1:0] w_read_data_next;
    logic [NBITS-1:0]       w_read_addr_out_next;
    logic                   w_read_valid_next;
    logic                   w_busy_next;
    logic                   w_scan_done_next;

    // The flattened bus is unpacked over the whole address space. Indices at
    // or above NUM_REGS are tied to zero, so an out-of-range address reads 0
    // without a separate range comparator.
    logic [WORD_LENGTH-1:0] w_words [0:ADDR_SPACE-1];

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_SPACE; gi++) begin : g_word
            if (gi >= NUM_REGS) begin : g_out_of_range
                assign w_words[gi] = '0;
            end else if (gi == 0) begin : g_index0
`ifdef ZERO_REG_EN
                // Register 0 is hard-wired to zero; its bus bits are not used.
                logic w_unused_word0;
                assign w_unused_word0 = ^Reg_Data[WORD_LENGTH-1:0];
                assign w_words[gi]    = '0;
`else
                assign w_words[gi] = Reg_Data[WORD_LENGTH-1:0];
`endif
            end else begin : g_in_range
                assign w_words[gi] = Reg_Data[gi*WORD_LENGTH +: WORD_LENGTH];
            end
        end
    endgenerate

    // Next state and outputs. Single reads complete in IDLE. SCAN walks the
    // counter and then spends one final cycle with Scan_Done already
    // registered, which drops Busy and returns to IDLE.
    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt;
        w_read_data_next     = r_read_data;
        w_read_addr_out_next = r_read_addr_out;
        w_read_valid_next    = 1'b0;
        w_busy_next          = r_busy;
        w_scan_done_next     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (Read_Req) begin
                    // A read takes priority. A simultaneous Scan_Start is dropped.
                    w_read_data_next     = w_words[Read_Addr];
                    w_read_addr_out_next = Read_Addr;
                    w_read_valid_next    = 1'b1;
                end else if (Scan_Start) begin
                    w_state_next = SCAN;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                end
            end
            SCAN: begin
                if (r_scan_done) begin
                    // The last word went out on the previous edge.
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_read_data_next     = w_words[r_cnt];
                    w_read_addr_out_next = r_cnt;
                    w_read_valid_next    = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        // Hold the counter here. It never wraps.
                        w_scan_done_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // Register update with synchronous active-low reset. Reset also aborts
    // any scan that is in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_read_data     <= '0;
            r_read_addr_out <= '0;
            r_read_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_scan_done     <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_read_data     <= w_read_data_next;
            r_read_addr_out <= w_read_addr_out_next;
            r_read_valid    <= w_read_valid_next;
            r_busy          <= w_busy_next;
            r_scan_done     <= w_scan_done_next;
        end
    end

    assign Read_Data     = r_read_data;
    assign Read_Addr_Out = r_read_addr_out;
    assign Read_Valid    = r_read_valid;
    assign Busy          = r_busy;
    assign Scan_Done     = r_scan_done;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed testbench for regfile_read_port. It checks with immediate
// assertions and uses the default parameters (32 x 32-bit words).
module tb_regfile_read_port;

    localparam int WL = 32;
    localparam int NR = 32;
    localparam int NB = 5;

    logic              clk;
    logic              reset;
    logic [NR*WL-1:0]  Reg_Data;
    logic              Read_Req;
    logic [NB-1:0]     Read_Addr;
    logic              Scan_Start;
    logic [WL-1:0]     Read_Data;
    logic [NB-1:0]     Read_Addr_Out;
    logic              Read_Valid;
    logic              Busy;
    logic              Scan_Done;

    int checks   = 0;
    int failures = 0;

    regfile_read_port #(
        .WORD_LENGTH (WL),
        .NUM_REGS    (NR),
        .NBITS       (NB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Reg_Data      (Reg_Data),
        .Read_Req      (Read_Req),
        .Read_Addr     (Read_Addr),
        .Scan_Start    (Scan_Start),
        .Read_Data     (Read_Data),
        .Read_Addr_Out (Read_Addr_Out),
        .Read_Valid    (Read_Valid),
        .Busy          (Busy),
        .Scan_Done     (Scan_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety bound so that the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        Reg_Data[idx*WL +: WL] = val;
    endtask

    // Wait for the next rising edge, then step 1 time unit past it to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int idx, input logic [31:0] val);
`ifdef ZERO_REG_EN
        if (idx == 0) return 32'h0;
`endif
        return val;
    endfunction

    int addrs [3] = '{3, 4, 31};

    initial begin
        reset      = 1'b0;
        Reg_Data   = '0;
        Read_Req   = 1'b0;
        Read_Addr  = '0;
        Scan_Start = 1'b0;

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst_data",  Read_Data,     32'h0);
        chk("rst_addr",  Read_Addr_Out, 32'h0);
        chk("rst_valid", Read_Valid,    32'h0);
        chk("rst_busy",  Busy,          32'h0);
        chk("rst_done",  Scan_Done,     32'h0);
        reset = 1'b1;
        tick();
        chk("idle_no_valid", Read_Valid, 32'h0);
        chk("idle_busy",     Busy,       32'h0);

        // Single read of word 7.
        set_word(7, 32'hDEAD_BEEF);
        Read_Req = 1'b1; Read_Addr = 5'd7;
        tick();
        chk("rd7_data",  Read_Data,     32'hDEAD_BEEF);
        chk("rd7_addr",  Read_Addr_Out, 32'd7);
        chk("rd7_valid", Read_Valid,    32'h1);
        Read_Req = 1'b0;
        tick();
        chk("rd7_valid_drop", Read_Valid, 32'h0);
        chk("rd7_hold_data",  Read_Data,  32'hDEAD_BEEF);
        chk("rd7_hold_addr",  Read_Addr_Out, 32'd7);

        // Back-to-back reads with word i = i+100.
        for (int i = 0; i < NR; i++) set_word(i, 32'(i + 100));
        for (int k = 0; k < 3; k++) begin
            Read_Req = 1'b1; Read_Addr = NB'(addrs[k]);
            tick();
            chk("b2b_data",  Read_Data,     32'(addrs[k] + 100));
            chk("b2b_addr",  Read_Addr_Out, 32'(addrs[k]));
            chk("b2b_valid", Read_Valid,    32'h1);
        end
        Read_Req = 1'b0;
        tick();
        chk("b2b_end_valid", Read_Valid, 32'h0);

        // Index 0 holding all ones.
        set_word(0, 32'hFFFF_FFFF);
        Read_Req = 1'b1; Read_Addr = 5'd0;
        tick();
        chk("zero_reg_data", Read_Data, exp_word(0, 32'hFFFF_FFFF));
        chk("zero_reg_addr", Read_Addr_Out, 32'd0);

        // Read_Req and Scan_Start together: only the read is serviced.
        Read_Addr = 5'd5; Scan_Start = 1'b1;
        tick();
        chk("both_data",  Read_Data,  32'd105);
        chk("both_valid", Read_Valid, 32'h1);
        chk("both_busy",  Busy,       32'h0);
        Read_Req = 1'b0; Scan_Start = 1'b0;
        tick();
        chk("both_busy2",  Busy,       32'h0);
        chk("both_valid2", Read_Valid, 32'h0);

        // Full scan with word i = 0x1000+i, plus requests injected mid-scan.
        for (int i = 0; i < NR; i++) set_word(i, 32'h1000 + 32'(i));
        Scan_Start = 1'b1;
        tick();
        Scan_Start = 1'b0;
        chk("scan_busy_start",  Busy,       32'h1);
        chk("scan_valid_start", Read_Valid, 32'h0);
        for (int i = 0; i < NR; i++) begin
            if (i == 5) begin Read_Req = 1'b1; Read_Addr = 5'd2; Scan_Start = 1'b1; end
            if (i == 9) begin Read_Req = 1'b0; Scan_Start = 1'b0; end
            tick();
            chk("scan_data",  Read_Data,     exp_word(i, 32'h1000 + 32'(i)));
            chk("scan_addr",  Read_Addr_Out, 32'(i));
            chk("scan_valid", Read_Valid,    32'h1);
            chk("scan_busy",  Busy,          32'h1);
            chk("scan_done",  Scan_Done,     (i == NR-1) ? 32'h1 : 32'h0);
        end
        tick();
        chk("scan_end_busy",  Busy,       32'h0);
        chk("scan_end_valid", Read_Valid, 32'h0);
        chk("scan_end_done",  Scan_Done,  32'h0);
        tick();
        chk("scan_idle_valid", Read_Valid, 32'h0);

        // Scan aborted by reset at index 10.
        Scan_Start = 1'b1;
        tick();
        Scan_Start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_pre_addr", Read_Addr_Out, 32'd9);
        reset = 1'b0;
        tick();
        chk("abort_data",  Read_Data,     32'h0);
        chk("abort_addr",  Read_Addr_Out, 32'h0);
        chk("abort_valid", Read_Valid,    32'h0);
        chk("abort_busy",  Busy,          32'h0);
        chk("abort_done",  Scan_Done,     32'h0);
        reset = 1'b1;
        tick();
        chk("abort_idle_valid", Read_Valid, 32'h0);
        chk("abort_idle_busy",  Busy,       32'h0);
        // A single read right after the abort is serviced at once, so the FSM is in IDLE.
        Read_Req = 1'b1; Read_Addr = 5'd3;
        tick();
        chk("abort_rd_data",  Read_Data,  32'h1003);
        chk("abort_rd_valid", Read_Valid, 32'h1);
        chk("abort_rd_busy",  Busy,       32'h0);
        Read_Req = 1'b0;
        tick();
        chk("final_valid", Read_Valid, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side companion to the register file's 1-to-32 write demultiplexer.
- Selects one word out of the flattened register-array bus and returns it registered, with a valid strobe.
- Also provides a sequential scan mode that streams every register out, one per cycle, for debug and dump logic.
- Sits between the register storage and the datapath/debug consumers.

Parameters:
- WORD_LENGTH, 32, width of each register word.
- NUM_REGS, 32, number of registers on the input bus (≤ 2**NBITS).
- NBITS, 5, address width; equals ceil(log2(NUM_REGS)).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- Reg_Data, input, NUM_REGS*WORD_LENGTH, flattened register contents; word i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- Read_Req, input, 1, single-read request; sampled on the rising edge.
- Read_Addr, input, NBITS, register index for the single read.
- Scan_Start, input, 1, starts a full scan; sampled on the rising edge.
- Read_Data, output, WORD_LENGTH, registered selected word.
- Read_Addr_Out, output, NBITS, index of the word currently on Read_Data.
- Read_Valid, output, 1, high for each cycle Read_Data carries a new word.
- Busy, output, 1, high while a scan is in progress.
- Scan_Done, output, 1, one-cycle pulse coincident with the last scanned word.

Behaviour:
- Reset is synchronous and active-low. With reset=0 at a clock edge:
  - all outputs go to 0 (Read_Data, Read_Addr_Out, Read_Valid, Busy, Scan_Done);
  - the FSM returns to IDLE and the scan counter clears to 0.
- FSM states are IDLE and SCAN; a single read completes from IDLE with no extra state.
- IDLE:
  - Read_Req=1 at edge N: at N+1, Read_Data = word[Read_Addr], Read_Addr_Out = Read_Addr, Read_Valid = 1 for one cycle. Latency is exactly 1 cycle.
  - Back-to-back Read_Req on consecutive cycles gives Read_Valid high on consecutive cycles. Throughput is 1 per cycle.
  - Scan_Start=1 with Read_Req=0: go to SCAN, counter=0, Busy=1 from the next edge.
  - Read_Req=1 and Scan_Start=1 together: the single read is serviced and Scan_Start is dropped (not queued).
- SCAN:
  - Each edge outputs word[counter], Read_Addr_Out = counter, Read_Valid = 1, then the counter increments.
  - First word appears 1 cycle after Scan_Start; NUM_REGS consecutive valid cycles follow.
  - On the word with counter = NUM_REGS-1: Scan_Done = 1 for that cycle. Busy drops to 0 on the following edge and the FSM returns to IDLE.
  - The counter never wraps past NUM_REGS-1.
  - Read_Req and Scan_Start are ignored while Busy=1; no queuing.
- Out-of-range Read_Addr (≥ NUM_REGS): Read_Data = 0, Read_Valid = 1, Read_Addr_Out = Read_Addr.
- No Read_Valid cycle: Read_Data and Read_Addr_Out hold their last values.
- Reset asserted mid-scan: the scan aborts at that edge, no Scan_Done is issued, and all outputs go to 0.
- Reg_Data is sampled at the edge the word is captured; a write-side change is visible on the next captured word.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined: index 0 always returns 0, regardless of Reg_Data word 0. This applies to both single reads and scans; all other behaviour is unchanged.
- Undefined: index 0 returns Reg_Data word 0 like any other register.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release -> all outputs 0 and Busy=0; no Read_Valid without a request.
- Single read: word 7 = 32'hDEAD_BEEF, Read_Req=1, Read_Addr=7 at edge N -> at N+1, Read_Data=32'hDEAD_BEEF, Read_Addr_Out=7, Read_Valid=1; Read_Valid=0 at N+2.
- Back-to-back reads: addresses 3, 4, 31 on consecutive cycles, word i = i+100 -> Read_Data 103, 104, 131 on three consecutive valid cycles.
- Full scan: word i = 32'h1000+i, pulse Scan_Start -> 32 consecutive valid cycles with data 32'h1000..32'h101F; Scan_Done only on index 31; Busy=0 one cycle later.
- Scan interference and abort:
  - Read_Req during scan -> ignored, and the data sequence is unchanged.
  - reset=0 at scan index 10 -> outputs 0 next cycle, no Scan_Done, FSM in IDLE.
- ZERO_REG_EN:
  - Defined: word 0 = 32'hFFFF_FFFF, read index 0 -> Read_Data=0.
  - Undefined: same stimulus -> Read_Data=32'hFFFF_FFFF.
  - Simultaneous Read_Req + Scan_Start -> single read only, Busy stays 0.
